dfii_init_seq: RTL and testbench
================================

DFII_INIT_SEQ -- requirements
Module: dfii_init_seq

Interface
REQ-001 SHALL have parameter TPOR_CYCLES, default 35, cycles dram_rst held after start.
REQ-002 SHALL have parameter TDLLK_CYCLES, default 600, wait after MR0 writes.
REQ-003 SHALL have parameter TZQINIT_CYCLES, default 600, wait after ZQCL.
REQ-004 SHALL have parameter THANDOFF_CYCLES, default 200, wait after hardware-control handoff before done.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 255, max cycles waiting for wb_ack per write.
REQ-006 SHALL have port clk  in  1  sole clock; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port start  in  1  single-cycle request to run the init sequence.
REQ-009 SHALL have ports busy, done, error  out  1 each  running / completed OK / aborted on ack timeout.
REQ-010 SHALL have port dram_rst  out  1  DRAM reset, active high.
REQ-011 SHALL have ports wb_adr out 30 (word address), wb_dat_w out 32, wb_sel out 4, wb_cyc, wb_stb, wb_we out 1, wb_ack in 1  Wishbone classic master to DFII CSRs.

Function
REQ-012 SHALL step through a fixed table; each entry is WRITE(word addr, data) or WAIT(cycles).
REQ-013 Table SHALL be, in order (CTRL=0x2400, CMD=0x2401, STB=0x2402, A=0x2403, BA=0x2404): WAIT TPOR with dram_rst=1; deassert dram_rst; A=0; BA=0; CTRL=0x0C; CTRL=0x0E; MR2 (A=0x200,BA=2,CMD=0x0F,STB=1); MR3 (A=0,BA=3,CMD=0x0F,STB=1); MR1 (A=0x6,BA=1,CMD=0x0F,STB=1); MR0 (A=0x320,BA=0,CMD=0x0F,STB=1); MR0 (A=0x220,BA=0,CMD=0x0F,STB=1); WAIT TDLLK; ZQCL (A=0x400,BA=0,CMD=0x03,STB=1); WAIT TZQINIT; CTRL=0x01; WAIT THANDOFF.
REQ-014 That is 29 WRITE entries in total; MRn groups SHALL write in order A, BA, CMD, STB.
REQ-015 FSM states SHALL be IDLE, POR, FETCH, WB_REQ, WB_GAP, WAIT, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR + start=1 -> POR next cycle: busy=1, done=0, error=0, step index=0.
REQ-017 start while busy SHALL be ignored.
REQ-018 POR SHALL hold dram_rst=1 for exactly TPOR_CYCLES cycles, then drive dram_rst=0 and go to FETCH.
REQ-019 FETCH SHALL decode the current entry in one cycle: WRITE -> WB_REQ; WAIT -> WAIT; past last entry -> DONE.
REQ-020 WB_REQ SHALL drive cyc=stb=we=1, sel=0xF, adr and dat_w stable until the cycle wb_ack=1 is sampled.
REQ-021 On ack, next cycle SHALL go to WB_GAP with cyc=stb=we=0 for exactly one cycle, then FETCH with index+1.
REQ-022 ack while cyc=0 SHALL be ignored.
REQ-023 WAIT SHALL count N cycles (N=0 treated as 1), then go to FETCH with index+1.
REQ-024 No ack within ACK_TIMEOUT cycles of stb rising SHALL go to ERROR: cyc=stb=0, busy=0, error=1 sticky until next start.
REQ-025 DONE SHALL set done=1, busy=0; outputs hold until next start.
REQ-026 Cycle counters SHALL be wide enough for the largest parameter, with no wrap before terminal count.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, index 0, counters 0, busy=done=error=0, dram_rst=1, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0.
REQ-028 Reset mid-transaction SHALL drop cyc/stb immediately with no pending ack tracked after release.

Structure
REQ-029 A shared package SHALL hold DFII CSR word addresses, CTRL bit constants (SEL=0x01, CKE=0x02, ODT=0x04, RESET_N=0x08), CMD bit constants (CS=0x01, WE=0x02, CAS=0x04, RAS=0x08), and the step-kind enum.
REQ-030 Step table SHALL be a combinational sub-module dfii_init_rom (index in; kind, addr, data/count out).

Verification
REQ-031 start with ack returned 1 cycle after stb -> 29 writes with exact addr/data of REQ-013 in order, done=1, busy=0.
REQ-032 TPOR_CYCLES=35 -> dram_rst high exactly 35 cycles after start accepted, first stb (adr 0x2403, data 0) no earlier than the cycle after dram_rst falls.
REQ-033 ack delayed 0..5 random cycles -> adr/dat_w stable while stb=1; exactly one idle cycle between writes; cycle gaps between MR0(0x220) STB write and ZQ A write = TDLLK_CYCLES + fixed overhead.
REQ-034 ack withheld on write #7 (MR2 CMD=0x0F) -> error=1 after 255 cycles, cyc=0; new start reruns from POR and completes.
REQ-035 rst_n pulsed low mid WB_REQ -> cyc/stb/we=0 and dram_rst=1 same cycle; start afterwards runs full sequence.
REQ-036 start pulsed again while busy -> sequence unaffected, 29 writes total.

Source files
------------

// File: rtl/dfii_init_seq_pkg.sv
// Shared definitions for the DFII DDR3 init sequencer.
// Holds the DFII CSR word addresses, CTRL/CMD bit constants, the step-kind
// enum consumed from the step ROM, the sequencer FSM state enum and a small
// helper used to size the cycle counters.
package dfii_init_seq_pkg;

  // DFII CSR word addresses (Wishbone word addressing)
  localparam logic [29:0] DFII_CTRL_ADR = 30'h2400;
  localparam logic [29:0] DFII_CMD_ADR  = 30'h2401;
  localparam logic [29:0] DFII_STB_ADR  = 30'h2402;
  localparam logic [29:0] DFII_A_ADR    = 30'h2403;
  localparam logic [29:0] DFII_BA_ADR   = 30'h2404;

  // CTRL register bits
  localparam logic [31:0] CTRL_SEL     = 32'h01;
  localparam logic [31:0] CTRL_CKE     = 32'h02;
  localparam logic [31:0] CTRL_ODT     = 32'h04;
  localparam logic [31:0] CTRL_RESET_N = 32'h08;

  // CMD register bits
  localparam logic [31:0] CMD_CS  = 32'h01;
  localparam logic [31:0] CMD_WE  = 32'h02;
  localparam logic [31:0] CMD_CAS = 32'h04;
  localparam logic [31:0] CMD_RAS = 32'h08;

  localparam logic [31:0] CMD_MRS  = CMD_CS | CMD_WE | CMD_CAS | CMD_RAS;
  localparam logic [31:0] CMD_ZQCL = CMD_CS | CMD_WE;

  localparam int STEP_IDX_W = 6;

  typedef enum logic [1:0] {
    STEP_WRITE = 2'd0,
    STEP_WAIT  = 2'd1,
    STEP_END   = 2'd2
  } step_kind_e;

  typedef enum logic [2:0] {
    S_IDLE, S_POR, S_FETCH, S_WB_REQ, S_WB_GAP, S_WAIT, S_DONE, S_ERROR
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dfii_init_rom.sv
// Combinational step table for the DDR3 init sequence.
//   idx_i  : step index
//   kind_o : WRITE / WAIT / END (END for any index past the table)
//   addr_o : CSR word address (WRITE)
//   data_o : CSR data (WRITE) or cycle count (WAIT)
// Steps 4..23 are the five mode-register groups (MR2, MR3, MR1, MR0, MR0),
// each written A, BA, CMD, STB; they are decoded from idx_i[4:2]/[1:0].
module dfii_init_rom
  import dfii_init_seq_pkg::*;
#(
  parameter int unsigned TDLLK_CYCLES    = 600,
  parameter int unsigned TZQINIT_CYCLES  = 600,
  parameter int unsigned THANDOFF_CYCLES = 200
) (
  input  logic [STEP_IDX_W-1:0] idx_i,
  output step_kind_e            kind_o,
  output logic [29:0]           addr_o,
  output logic [31:0]           data_o
);

  logic [31:0] mr_a;
  logic [31:0] mr_ba;

  // idx_i[4:2] = 1..5 selects MR2, MR3, MR1, MR0 (DLL reset), MR0
  always_comb begin
    mr_a  = 32'h220;
    mr_ba = 32'h0;
    case (idx_i[4:2])
      3'd1:    begin mr_a = 32'h200; mr_ba = 32'h2; end
      3'd2:    begin mr_a = 32'h000; mr_ba = 32'h3; end
      3'd3:    begin mr_a = 32'h006; mr_ba = 32'h1; end
      3'd4:    begin mr_a = 32'h320; mr_ba = 32'h0; end
      default: begin mr_a = 32'h220; mr_ba = 32'h0; end
    endcase
  end

  always_comb begin
    kind_o = STEP_END;
    addr_o = '0;
    data_o = '0;
    if (idx_i >= 6'd4 && idx_i <= 6'd23) begin
      kind_o = STEP_WRITE;
      case (idx_i[1:0])
        2'd0:    begin addr_o = DFII_A_ADR;   data_o = mr_a;    end
        2'd1:    begin addr_o = DFII_BA_ADR;  data_o = mr_ba;   end
        2'd2:    begin addr_o = DFII_CMD_ADR; data_o = CMD_MRS; end
        default: begin addr_o = DFII_STB_ADR; data_o = 32'h1;   end
      endcase
    end else begin
      case (idx_i)
        6'd0:  begin kind_o = STEP_WRITE; addr_o = DFII_A_ADR;    data_o = 32'h0; end
        6'd1:  begin kind_o = STEP_WRITE; addr_o = DFII_BA_ADR;   data_o = 32'h0; end
        6'd2:  begin kind_o = STEP_WRITE; addr_o = DFII_CTRL_ADR; data_o = CTRL_RESET_N | CTRL_ODT; end
        6'd3:  begin kind_o = STEP_WRITE; addr_o = DFII_CTRL_ADR; data_o = CTRL_RESET_N | CTRL_ODT | CTRL_CKE; end
        6'd24: begin kind_o = STEP_WAIT;  data_o = 32'(TDLLK_CYCLES); end
        6'd25: begin kind_o = STEP_WRITE; addr_o = DFII_A_ADR;    data_o = 32'h400; end
        6'd26: begin kind_o = STEP_WRITE; addr_o = DFII_BA_ADR;   data_o = 32'h0; end
        6'd27: begin kind_o = STEP_WRITE; addr_o = DFII_CMD_ADR;  data_o = CMD_ZQCL; end
        6'd28: begin kind_o = STEP_WRITE; addr_o = DFII_STB_ADR;  data_o = 32'h1; end
        6'd29: begin kind_o = STEP_WAIT;  data_o = 32'(TZQINIT_CYCLES); end
        6'd30: begin kind_o = STEP_WRITE; addr_o = DFII_CTRL_ADR; data_o = CTRL_SEL; end
        6'd31: begin kind_o = STEP_WAIT;  data_o = 32'(THANDOFF_CYCLES); end
        default: kind_o = STEP_END;
      endcase
    end
  end

endmodule

// File: rtl/dfii_init_seq.sv
// DDR3 power-up init sequencer driving the DFII CSRs over Wishbone classic.
//   clk, rst_n        : clock, async active-low reset
//   start             : one-cycle request to (re)run the sequence
//   busy/done/error   : running / finished OK / aborted on ack timeout
//   dram_rst          : DRAM reset, active high
//   wb_*              : Wishbone classic master (word address)
// Holds dram_rst for TPOR cycles, then walks the step table in dfii_init_rom.
// Each write is one Wishbone cycle followed by a one-cycle gap and a fetch.
module dfii_init_seq
  import dfii_init_seq_pkg::*;
#(
  parameter int unsigned TPOR_CYCLES     = 35,
  parameter int unsigned TDLLK_CYCLES    = 600,
  parameter int unsigned TZQINIT_CYCLES  = 600,
  parameter int unsigned THANDOFF_CYCLES = 200,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        dram_rst,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack
);

  // One spare bit so the counter cannot wrap before any terminal count.
  localparam int unsigned MAXP = max_u(max_u(TPOR_CYCLES, TDLLK_CYCLES),
                                       max_u(max_u(TZQINIT_CYCLES, THANDOFF_CYCLES), ACK_TIMEOUT));
  localparam int CNT_W = $clog2(MAXP + 1) + 1;

  localparam int unsigned TPOR_EFF = (TPOR_CYCLES == 0) ? 1 : TPOR_CYCLES;
  localparam int unsigned ACK_EFF  = (ACK_TIMEOUT == 0) ? 1 : ACK_TIMEOUT;
  localparam logic [CNT_W-1:0] TPOR_LAST = CNT_W'(TPOR_EFF - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e                state_q;
  logic [STEP_IDX_W-1:0] idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      wait_n_q;

  step_kind_e  rom_kind;
  logic [29:0] rom_addr;
  logic [31:0] rom_data;

  dfii_init_rom #(
    .TDLLK_CYCLES    (TDLLK_CYCLES),
    .TZQINIT_CYCLES  (TZQINIT_CYCLES),
    .THANDOFF_CYCLES (THANDOFF_CYCLES)
  ) u_rom (
    .idx_i  (idx_q),
    .kind_o (rom_kind),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      wait_n_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      dram_rst <= 1'b1;
      wb_adr   <= '0;
      wb_dat_w <= '0;
      wb_sel   <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q  <= S_POR;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            dram_rst <= 1'b1;
          end
        end
        S_POR: begin
          if (cnt_q == TPOR_LAST) begin
            dram_rst <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FETCH: begin
          cnt_q <= '0;
          case (rom_kind)
            STEP_WRITE: begin
              wb_adr   <= rom_addr;
              wb_dat_w <= rom_data;
              wb_sel   <= 4'hF;
              wb_cyc   <= 1'b1;
              wb_stb   <= 1'b1;
              wb_we    <= 1'b1;
              state_q  <= S_WB_REQ;
            end
            STEP_WAIT: begin
              // A zero-length wait still spends one cycle.
              wait_n_q <= (rom_data == 32'h0) ? CNT_ONE : rom_data[CNT_W-1:0];
              state_q  <= S_WAIT;
            end
            default: begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end
          endcase
        end
        S_WB_REQ: begin
          if (wb_ack) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            state_q <= S_WB_GAP;
          end else if (cnt_q == ACK_LAST) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WB_GAP: begin
          idx_q   <= idx_q + 6'd1;
          state_q <= S_FETCH;
        end
        S_WAIT: begin
          if (cnt_q + CNT_ONE >= wait_n_q) begin
            idx_q   <= idx_q + 6'd1;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfii_init_seq.sv
// Directed bench for dfii_init_seq: full sequence, random ack latency,
// ack timeout with rerun, reset during a bus cycle, and start while busy.
module tb_dfii_init_seq;

  localparam int TDLLK = 600;
  localparam int TZQ   = 600;

  logic        clk;
  logic        rst_n, start, wb_ack;
  logic        busy, done, error, dram_rst;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we;

  dfii_init_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .error(error), .dram_rst(dram_rst),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] exp_adr [29];
  logic [31:0] exp_dat [29];

  // bus monitor state
  logic [29:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic [3:0]  log_sel [$];
  int          gaps [$];
  int          unstable, run, last_run, idle;
  logic        prev_stb;
  logic [29:0] prev_adr;
  logic [31:0] prev_dat;

  // responder controls
  bit rand_ack    = 0;
  bit withhold_en = 0;
  bit stray_pulse = 0;
  int d;
  bit ok_ack;

  // Wishbone slave: acks after 0 (or 0..5 random) cycles; can withhold the
  // 7th write; can emit one stray ack while cyc is low.
  initial begin
    wb_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stray_pulse && !wb_cyc) begin
        wb_ack = 1'b1; @(posedge clk); #1; wb_ack = 1'b0; stray_pulse = 0;
      end else if (rst_n && wb_cyc && wb_stb && !(withhold_en && log_adr.size() == 6)) begin
        d = rand_ack ? int'($urandom_range(0, 5)) : 0;
        ok_ack = 1;
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          if (!wb_stb) ok_ack = 0;
        end
        if (ok_ack && wb_stb) begin
          wb_ack = 1'b1; @(posedge clk); #1; wb_ack = 1'b0;
        end
      end
    end
  end

  // Monitor on the falling edge: logs accepted writes, idle gaps between
  // strobes, stb run lengths and any adr/data change while stb is held.
  initial begin
    prev_stb = 0; run = 0; last_run = 0; idle = 0; unstable = 0;
    prev_adr = '0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stb = 0; run = 0; idle = 0;
      end else begin
        if (wb_stb) begin
          if (!prev_stb) begin
            if (log_adr.size() > 0) gaps.push_back(idle);
            run = 0;
          end else if (wb_adr !== prev_adr || wb_dat_w !== prev_dat) begin
            unstable++;
          end
          run++;
          idle = 0;
          if (wb_cyc && wb_ack) begin
            log_adr.push_back(wb_adr); log_dat.push_back(wb_dat_w); log_sel.push_back(wb_sel);
          end
        end else begin
          if (prev_stb) last_run = run;
          idle++;
        end
        prev_stb = wb_stb; prev_adr = wb_adr; prev_dat = wb_dat_w;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_adr.delete(); log_dat.delete(); log_sel.delete(); gaps.delete();
    unstable = 0; last_run = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      if (done || error) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, error, dram_rst, wb_cyc, wb_stb, wb_we} !== 7'b0001000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0001000", {busy, done, error, dram_rst, wb_cyc, wb_stb, wb_we});
    end
    n_checks++;
    if ({wb_adr, wb_dat_w, wb_sel} !== 66'h0) begin
      n_fail++; $display("FAIL reset_bus: adr %h dat %h sel %h want 0", wb_adr, wb_dat_w, wb_sel);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || dram_rst !== 1'b1) begin
      n_fail++; $display("FAIL idle_after_reset: busy %b dram_rst %b want 0 1", busy, dram_rst);
    end
  endtask

  task automatic test_full_seq();
    int cnt, k, mm, badgap;
    bit ok;
    clear_log(); rand_ack = 0;
    do_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL start_accept: busy %b done %b error %b want 1 0 0", busy, done, error);
    end
    stray_pulse = 1;
    cnt = 0;
    while (dram_rst === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_checks++;
    if (cnt != 35) begin n_fail++; $display("FAIL tpor_len: dram_rst high %0d cycles want 35", cnt); end
    k = 0;
    while (wb_stb !== 1'b1 && k < 10) begin k++; @(negedge clk); end
    n_checks++;
    if (k < 1 || k >= 10) begin n_fail++; $display("FAIL first_stb_delay: %0d cycles after dram_rst fall want >=1", k); end
    n_checks++;
    if (wb_adr !== 30'h2403 || wb_dat_w !== 32'h0) begin
      n_fail++; $display("FAIL first_write: adr %h dat %h want 2403 0", wb_adr, wb_dat_w);
    end
    wait_end(ok);
    n_checks++;
    if (!ok || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL full_done: ok %0d done %b busy %b error %b", ok, done, busy, error);
    end
    n_checks++;
    if (log_adr.size() != 29) begin n_fail++; $display("FAIL full_count: %0d writes want 29", log_adr.size()); end
    mm = 0;
    for (int i = 0; i < log_adr.size() && i < 29; i++)
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i] || log_sel[i] !== 4'hF) begin
        if (mm == 0) $display("FAIL full_entry %0d: adr %h dat %h sel %h want %h %h f",
                              i, log_adr[i], log_dat[i], log_sel[i], exp_adr[i], exp_dat[i]);
        mm++;
      end
    n_checks++;
    if (mm != 0) begin n_fail++; $display("FAIL full_table: %0d entries differ want 0", mm); end
    badgap = 0;
    for (int i = 0; i < gaps.size(); i++) if (i != 23 && i != 27 && gaps[i] != 2) badgap++;
    n_checks++;
    if (gaps.size() != 28 || badgap != 0) begin
      n_fail++; $display("FAIL write_gaps: %0d gaps, %0d not 2, want 28 and 0", gaps.size(), badgap);
    end
    n_checks++;
    if (gaps.size() != 28 || gaps[23] != TDLLK + 3 || gaps[27] != TZQ + 3) begin
      n_fail++; $display("FAIL wait_gaps: got %0d %0d want %0d %0d",
                         gaps.size() > 23 ? gaps[23] : -1, gaps.size() > 27 ? gaps[27] : -1, TDLLK + 3, TZQ + 3);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || dram_rst !== 1'b0 || wb_cyc !== 1'b0) begin
      n_fail++; $display("FAIL done_hold: done %b dram_rst %b cyc %b want 1 0 0", done, dram_rst, wb_cyc);
    end
  endtask

  task automatic test_random_ack();
    int mm, badgap;
    bit ok;
    clear_log(); rand_ack = 1;
    do_start();
    wait_end(ok);
    rand_ack = 0;
    n_checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL rand_done: ok %0d done %b error %b", ok, done, error);
    end
    mm = 0;
    for (int i = 0; i < log_adr.size() && i < 29; i++)
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) mm++;
    n_checks++;
    if (log_adr.size() != 29 || mm != 0) begin
      n_fail++; $display("FAIL rand_table: %0d writes %0d differ want 29 0", log_adr.size(), mm);
    end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL rand_stable: %0d changes while stb want 0", unstable); end
    badgap = 0;
    for (int i = 0; i < gaps.size(); i++) if (i != 23 && i != 27 && gaps[i] != 2) badgap++;
    n_checks++;
    if (gaps.size() != 28 || badgap != 0 || gaps[23] != TDLLK + 3) begin
      n_fail++; $display("FAIL rand_gaps: %0d gaps %0d bad want 28 0", gaps.size(), badgap);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log(); withhold_en = 1;
    do_start();
    wait_end(ok);
    n_checks++;
    if (!ok || error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: ok %0d error %b done %b busy %b want 1 1 0 0", ok, error, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      n_fail++; $display("FAIL timeout_bus: cyc %b stb %b want 0 0", wb_cyc, wb_stb);
    end
    n_checks++;
    if (last_run != 255) begin n_fail++; $display("FAIL timeout_len: stb held %0d cycles want 255", last_run); end
    n_checks++;
    if (log_adr.size() != 6) begin n_fail++; $display("FAIL timeout_writes: %0d acked want 6", log_adr.size()); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: error %b want 1", error); end
    withhold_en = 0; clear_log();
    do_start();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1 || dram_rst !== 1'b1) begin
      n_fail++; $display("FAIL rerun_start: error %b busy %b dram_rst %b want 0 1 1", error, busy, dram_rst);
    end
    wait_end(ok);
    n_checks++;
    if (!ok || done !== 1'b1 || log_adr.size() != 29) begin
      n_fail++; $display("FAIL rerun_done: done %b writes %0d want 1 29", done, log_adr.size());
    end
  endtask

  task automatic test_reset_mid();
    int k, mm;
    bit ok;
    clear_log();
    do_start();
    k = 0;
    while (!(wb_stb === 1'b1 && wb_dat_w === 32'hE) && k < 500) begin k++; @(negedge clk); end
    n_checks++;
    if (k >= 500) begin n_fail++; $display("FAIL rstmid_reach: write CTRL=0E not seen"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc, wb_stb, wb_we, dram_rst, busy} !== 5'b00010) begin
      n_fail++; $display("FAIL rstmid_async: cyc/stb/we/dram_rst/busy %b want 00010", {wb_cyc, wb_stb, wb_we, dram_rst, busy});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wb_cyc !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: busy %b cyc %b want 0 0", busy, wb_cyc);
    end
    clear_log();
    do_start();
    wait_end(ok);
    mm = 0;
    for (int i = 0; i < log_adr.size() && i < 29; i++)
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) mm++;
    n_checks++;
    if (!ok || done !== 1'b1 || log_adr.size() != 29 || mm != 0) begin
      n_fail++; $display("FAIL rstmid_rerun: done %b writes %0d differ %0d want 1 29 0", done, log_adr.size(), mm);
    end
  endtask

  task automatic test_back_to_back();
    int k, mm;
    bit ok;
    clear_log();
    do_start();
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    k = 0;
    while (log_adr.size() < 5 && k < 500) begin k++; @(negedge clk); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_end(ok);
    mm = 0;
    for (int i = 0; i < log_adr.size() && i < 29; i++)
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) mm++;
    n_checks++;
    if (!ok || done !== 1'b1 || log_adr.size() != 29 || mm != 0) begin
      n_fail++; $display("FAIL busy_start: done %b writes %0d differ %0d want 1 29 0", done, log_adr.size(), mm);
    end
  endtask

  initial begin
    exp_adr = '{30'h2403, 30'h2404, 30'h2400, 30'h2400,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2403, 30'h2404, 30'h2401, 30'h2402,
                30'h2400};
    exp_dat = '{32'h0,   32'h0, 32'h0C, 32'h0E,
                32'h200, 32'h2, 32'h0F, 32'h1,
                32'h0,   32'h3, 32'h0F, 32'h1,
                32'h6,   32'h1, 32'h0F, 32'h1,
                32'h320, 32'h0, 32'h0F, 32'h1,
                32'h220, 32'h0, 32'h0F, 32'h1,
                32'h400, 32'h0, 32'h03, 32'h1,
                32'h1};
    test_reset();
    test_full_seq();
    test_random_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
